// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states, instruction
// fields, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StRst,
        StFetch,
        StDecode,
        StExecR,
        StAluWait,
        StRWb,
        StExecI,
        StIWb,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StBranch,
        StJump,
        StTrap
    } state_e;

    localparam logic [5:0] OpcRType = 6'b000000;
    localparam logic [5:0] OpcLw    = 6'b100011;
    localparam logic [5:0] OpcSw    = 6'b101011;
    localparam logic [5:0] OpcBeq   = 6'b000100;
    localparam logic [5:0] OpcJ     = 6'b000010;
    localparam logic [5:0] OpcAddi  = 6'b001000;
    localparam logic [5:0] OpcAndi  = 6'b001100;
    localparam logic [5:0] OpcOri   = 6'b001101;
    localparam logic [5:0] OpcSlti  = 6'b001010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnMul = 6'b011000;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluAnd = 3'd2;
    localparam logic [2:0] AluOr  = 3'd3;
    localparam logic [2:0] AluSlt = 3'd4;
    localparam logic [2:0] AluMul = 3'd5;

    localparam logic [1:0] BSrcRegB   = 2'd0;
    localparam logic [1:0] BSrcFour   = 2'd1;
    localparam logic [1:0] BSrcImm    = 2'd2;
    localparam logic [1:0] BSrcImmSh2 = 2'd3;

    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    function automatic logic [2:0] imm_alu_op(input logic [5:0] opc);
        logic [2:0] op;
        op = AluAdd;
        case (opc)
            OpcAndi: op = AluAnd;
            OpcOri:  op = AluOr;
            OpcSlti: op = AluSlt;
            default: op = AluAdd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct decoder: ALU operation, legality and multicycle (needs ALU wait) flags.
module mc_alu_decode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned ALUOP_W = 5
) (
    input  logic [FUNCT_W-1:0] funct,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               legal,
    output logic               multicycle
);

    logic [5:0] fn;
    assign fn = 6'(funct);

    always_comb begin
        alu_op     = ALUOP_W'(AluAdd);
        legal      = 1'b1;
        multicycle = 1'b0;
        case (fn)
            FnAdd: alu_op = ALUOP_W'(AluAdd);
            FnSub: alu_op = ALUOP_W'(AluSub);
            FnAnd: alu_op = ALUOP_W'(AluAnd);
            FnOr:  alu_op = ALUOP_W'(AluOr);
            FnSlt: alu_op = ALUOP_W'(AluSlt);
            FnMul: begin
                alu_op     = ALUOP_W'(AluMul);
                multicycle = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle CPU control FSM with memory handshake, bounded ALU waits and jump path.
// Define MULTICYCLE_CTRL_TRAP_EN to build the sticky illegal-instruction TRAP state.
module multicycle_ctrl_v2
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W        = 6,
    parameter int unsigned FUNCT_W      = 6,
    parameter int unsigned ALUOP_W      = 5,
    parameter int unsigned ALU_WAIT_MAX = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               memready,
    input  logic               aludone,
    input  logic [OPC_W-1:0]   Opcode,
    input  logic [FUNCT_W-1:0] AluFunc,
    output logic               MemtoRegSel,
    output logic               MemWriteEn,
    output logic               BranchEn,
    output logic [ALUOP_W-1:0] AluOp,
    output logic               ALUASrcSel,
    output logic [1:0]         ALUBSrcSel,
    output logic               RegDstSel,
    output logic               RegWriteEn,
    output logic [1:0]         PCSrcSel,
    output logic               PCWrite,
    output logic               IorDSel,
    output logic               IRWriteEn,
    output logic               trap,
    output logic               busy
);

    // Counter holds completed ALU_WAIT cycles, so it only has to reach ALU_WAIT_MAX-1.
    localparam int unsigned CntW = (ALU_WAIT_MAX > 1) ? $clog2(ALU_WAIT_MAX) : 1;
    localparam logic [CntW-1:0] WaitLast = CntW'((ALU_WAIT_MAX == 0) ? 0 : ALU_WAIT_MAX - 1);

`ifdef MULTICYCLE_CTRL_TRAP_EN
    localparam state_e IllegalNext = StTrap;
`else
    localparam state_e IllegalNext = StFetch;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            wait_expired;

    logic [5:0]         opc;
    logic [ALUOP_W-1:0] fn_alu_op;
    logic               fn_legal;
    logic               fn_multicycle;

    assign opc = 6'(Opcode);

    mc_alu_decode #(
        .FUNCT_W (FUNCT_W),
        .ALUOP_W (ALUOP_W)
    ) u_alu_decode (
        .funct      (AluFunc),
        .alu_op     (fn_alu_op),
        .legal      (fn_legal),
        .multicycle (fn_multicycle)
    );

    assign wait_expired = (ALU_WAIT_MAX != 0) && (wait_cnt_q == WaitLast);
    assign wait_cnt_d   = (state_q == StAluWait) ? wait_cnt_q + CntW'(1) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRst;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        MemtoRegSel = 1'b0;
        MemWriteEn  = 1'b0;
        BranchEn    = 1'b0;
        AluOp       = ALUOP_W'(AluAdd);
        ALUASrcSel  = 1'b0;
        ALUBSrcSel  = BSrcRegB;
        RegDstSel   = 1'b0;
        RegWriteEn  = 1'b0;
        PCSrcSel    = PcSrcAlu;
        PCWrite     = 1'b0;
        IorDSel     = 1'b0;
        IRWriteEn   = 1'b0;
        trap        = 1'b0;
        busy        = 1'b1;

        case (state_q)
            // RST drives every output low, busy included.
            StRst: begin
                busy    = 1'b0;
                state_d = StFetch;
            end
            StFetch: begin
                busy       = 1'b0;
                ALUBSrcSel = BSrcFour;
                IRWriteEn  = memready;
                PCWrite    = memready;
                if (memready) state_d = StDecode;
            end
            StDecode: begin
                ALUBSrcSel = BSrcImmSh2;
                case (opc)
                    OpcRType:                          state_d = fn_legal ? StExecR : IllegalNext;
                    OpcLw, OpcSw:                      state_d = StMemAddr;
                    OpcBeq:                            state_d = StBranch;
                    OpcJ:                              state_d = StJump;
                    OpcAddi, OpcAndi, OpcOri, OpcSlti: state_d = StExecI;
                    default:                           state_d = IllegalNext;
                endcase
            end
            StExecR: begin
                ALUASrcSel = 1'b1;
                AluOp      = fn_alu_op;
                state_d    = fn_multicycle ? StAluWait : StRWb;
            end
            StAluWait: begin
                ALUASrcSel = 1'b1;
                AluOp      = fn_alu_op;
                if (aludone || wait_expired) state_d = StRWb;
            end
            StRWb: begin
                RegDstSel  = 1'b1;
                RegWriteEn = 1'b1;
                state_d    = StFetch;
            end
            StExecI: begin
                ALUASrcSel = 1'b1;
                ALUBSrcSel = BSrcImm;
                AluOp      = ALUOP_W'(imm_alu_op(opc));
                state_d    = StIWb;
            end
            StIWb: begin
                RegWriteEn = 1'b1;
                state_d    = StFetch;
            end
            StMemAddr: begin
                ALUASrcSel = 1'b1;
                ALUBSrcSel = BSrcImm;
                state_d    = (opc == OpcSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                IorDSel = 1'b1;
                if (memready) state_d = StMemWb;
            end
            StMemWb: begin
                MemtoRegSel = 1'b1;
                RegWriteEn  = 1'b1;
                state_d     = StFetch;
            end
            StMemWr: begin
                IorDSel    = 1'b1;
                MemWriteEn = 1'b1;
                if (memready) state_d = StFetch;
            end
            StBranch: begin
                ALUASrcSel = 1'b1;
                AluOp      = ALUOP_W'(AluSub);
                BranchEn   = 1'b1;
                PCSrcSel   = PcSrcAluOut;
                state_d    = StFetch;
            end
            StJump: begin
                PCWrite  = 1'b1;
                PCSrcSel = PcSrcJump;
                state_d  = StFetch;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            StTrap: begin
                trap = 1'b1;
            end
`endif
            default: state_d = StFetch;
        endcase
    end

endmodule
